// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-direction intersection sequencer with per-direction countdowns.
// Define TLF_ALL_RED_EN to insert all-red clearance phases after each yellow.
module traffic_light_fsm #(
   parameter int GREEN_TIME  = 25,
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 2,
   parameter int TICK_DIV    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] count1,
   output logic [7:0] count2,
   output logic [2:0] light1,
   output logic [2:0] light2
);

`ifdef TLF_ALL_RED_EN
   localparam int AR_TIME = ALLRED_TIME;
`else
   localparam int AR_TIME = 0;
`endif

   localparam int         PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [7:0] G_LEN    = 8'(GREEN_TIME);
   localparam logic [7:0] Y_LEN    = 8'(YELLOW_TIME);
   localparam logic [7:0] A_LEN    = 8'(AR_TIME);
   localparam logic [7:0] HALF_LEN = 8'(GREEN_TIME + YELLOW_TIME + AR_TIME);

   localparam logic [2:0] LAMP_G = 3'b001;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_R = 3'b100;

   typedef enum logic [2:0] {
      S_G1  = 3'd0,
      S_Y1  = 3'd1,
      S_AR1 = 3'd2,
      S_G2  = 3'd3,
      S_Y2  = 3'd4,
      S_AR2 = 3'd5
   } state_t;

   state_t     r_state;
   logic [7:0] r_t;
   logic       w_tick;
   logic       w_state_ok;

   generate
      if (TICK_DIV > 1) begin : g_presc
         logic [PW-1:0] r_presc;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_presc <= '0;
            end else if (w_tick) begin
               r_presc <= '0;
            end else begin
               r_presc <= r_presc + 1'b1;
            end
         end

         assign w_tick = (r_presc == PW'(TICK_DIV - 1));
      end else begin : g_no_presc
         assign w_tick = 1'b1;
      end
   endgenerate

   assign w_state_ok = (r_state inside {S_G1, S_Y1, S_AR1, S_G2, S_Y2, S_AR2});

   // A timer of 0 can only come from an upset; treat it as expiry so the phase still ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_G1;
         r_t     <= G_LEN;
      end else if (!w_state_ok) begin
         r_state <= S_G1;
         r_t     <= G_LEN;
      end else if (w_tick) begin
         if (r_t > 8'd1) begin
            r_t <= r_t - 8'd1;
         end else begin
            case (r_state)
               S_G1: begin
                  r_state <= S_Y1;
                  r_t     <= Y_LEN;
               end
               S_Y1: begin
`ifdef TLF_ALL_RED_EN
                  r_state <= S_AR1;
                  r_t     <= A_LEN;
`else
                  r_state <= S_G2;
                  r_t     <= G_LEN;
`endif
               end
               S_AR1: begin
                  r_state <= S_G2;
                  r_t     <= G_LEN;
               end
               S_G2: begin
                  r_state <= S_Y2;
                  r_t     <= Y_LEN;
               end
               S_Y2: begin
`ifdef TLF_ALL_RED_EN
                  r_state <= S_AR2;
                  r_t     <= A_LEN;
`else
                  r_state <= S_G1;
                  r_t     <= G_LEN;
`endif
               end
               default: begin
                  r_state <= S_G1;
                  r_t     <= G_LEN;
               end
            endcase
         end
      end
   end

   // Red lights count to their next green, so they include the other side's remaining phases.
   always_comb begin
      light1 = LAMP_R;
      light2 = LAMP_R;
      count1 = r_t;
      count2 = r_t;
      case (r_state)
         S_G1: begin
            light1 = LAMP_G;
            count2 = r_t + Y_LEN + A_LEN;
         end
         S_Y1: begin
            light1 = LAMP_Y;
            count2 = r_t + A_LEN;
         end
         S_AR1: begin
            count1 = r_t + HALF_LEN;
         end
         S_G2: begin
            light2 = LAMP_G;
            count1 = r_t + Y_LEN + A_LEN;
         end
         S_Y2: begin
            light2 = LAMP_Y;
            count1 = r_t + A_LEN;
         end
         S_AR2: begin
            count2 = r_t + HALF_LEN;
         end
         default: begin
            light1 = LAMP_R;
            light2 = LAMP_R;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: directed checks of the light sequence, countdowns, reset and prescaler.
module tb_traffic_light_fsm;

`ifdef TLF_ALL_RED_EN
   localparam int AR = 2;
`else
   localparam int AR = 0;
`endif
   localparam int G    = 25;
   localparam int Y    = 3;
   localparam int HALF = G + Y + AR;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] count1, count2, count1_d4, count2_d4;
   logic [2:0] light1, light2, light1_d4, light2_d4;

   int n_checks = 0;
   int n_errors = 0;

   always #10 clk = ~clk;

   traffic_light_fsm u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .count1 (count1),
      .count2 (count2),
      .light1 (light1),
      .light2 (light2)
   );

   traffic_light_fsm #(.TICK_DIV(4)) u_dut_d4 (
      .clk    (clk),
      .rst_n  (rst_n),
      .count1 (count1_d4),
      .count2 (count2_d4),
      .light1 (light1_d4),
      .light2 (light2_d4)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_main(input string tag, input int l1, input int l2, input int c1, input int c2);
      $display("vec %-10s t=%0t light1=%b light2=%b count1=%0d count2=%0d", tag, $time, light1, light2, count1, count2);
      check({tag, ".light1"}, int'(light1), l1);
      check({tag, ".light2"}, int'(light2), l2);
      check({tag, ".count1"}, int'(count1), c1);
      check({tag, ".count2"}, int'(count2), c2);
   endtask

   task automatic expect_d4(input string tag, input int l1, input int l2, input int c1, input int c2);
      $display("vec %-10s t=%0t light1=%b light2=%b count1=%0d count2=%0d", tag, $time, light1_d4, light2_d4, count1_d4, count2_d4);
      check({tag, ".light1"}, int'(light1_d4), l1);
      check({tag, ".light2"}, int'(light2_d4), l2);
      check({tag, ".count1"}, int'(count1_d4), c1);
      check({tag, ".count2"}, int'(count2_d4), c2);
   endtask

   // Advance n rising edges, then sit 1 ns past the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // 1: reset held
      rst_n = 1'b0;
      edges(3);
      expect_main("rst", 1, 4, G, HALF);
      expect_d4("rst_d4", 1, 4, G, HALF);

      // 2/3: one full cycle from release
      rst_n = 1'b1;
      edges(24);
      expect_main("g1_end", 1, 4, 1, 1 + Y + AR);
      edges(1);
      expect_main("y1_entry", 2, 4, 3, 3 + AR);
      edges(2);
      expect_main("y1_end", 2, 4, 1, 1 + AR);
      edges(1);
`ifdef TLF_ALL_RED_EN
      expect_main("ar1_entry", 4, 4, 2 + HALF, 2);
      edges(AR);
`endif
      expect_main("g2_entry", 4, 1, HALF, G);
      edges(G - 1);
      expect_main("g2_end", 4, 1, 1 + Y + AR, 1);
      edges(1);
      expect_main("y2_entry", 4, 2, 3 + AR, 3);
      edges(2);
      expect_main("y2_end", 4, 2, 1 + AR, 1);
      edges(1);
`ifdef TLF_ALL_RED_EN
      expect_main("ar2_entry", 4, 4, 2, 2 + HALF);
      edges(AR);
`endif
      expect_main("wrap_g1", 1, 4, G, HALF);

      // 4: invariants over a long run
      for (int i = 0; i < 200; i++) begin
         edges(1);
         check("safe", int'(light1 == 3'b100 || light2 == 3'b100), 1);
         check("onehot1", int'($onehot(light1)), 1);
         check("onehot2", int'($onehot(light2)), 1);
         check("range1", int'(count1 >= 8'd1 && count1 <= 8'(HALF)), 1);
         check("range2", int'(count2 >= 8'd1 && count2 <= 8'(HALF)), 1);
      end
      $display("run 200 clks done, checks so far %0d", n_checks);

      // 5: asynchronous reset in the middle of Y2
      rst_n = 1'b0;
      edges(2);
      rst_n = 1'b1;
      edges(54 + AR);
      expect_main("mid_y2", 4, 2, 2 + AR, 2);
      #5 rst_n = 1'b0;
      #1;
      expect_main("async_rst", 1, 4, G, HALF);
      edges(1);
      expect_main("rst_hold", 1, 4, G, HALF);
      rst_n = 1'b1;
      edges(1);
      expect_main("restart", 1, 4, G - 1, G - 1 + Y + AR);

      // 6: TICK_DIV=4 phase lengths
      rst_n = 1'b0;
      edges(2);
      rst_n = 1'b1;
      edges(99);
      expect_d4("d4_g1_end", 1, 4, 1, 1 + Y + AR);
      edges(1);
      expect_d4("d4_y1", 2, 4, 3, 3 + AR);
      edges(11);
      expect_d4("d4_y1_end", 2, 4, 1, 1 + AR);
      edges(1);
`ifdef TLF_ALL_RED_EN
      expect_d4("d4_ar1", 4, 4, 2 + HALF, 2);
      edges(7);
      expect_d4("d4_ar1_end", 4, 4, 1 + HALF, 1);
      edges(1);
`endif
      expect_d4("d4_g2", 4, 1, HALF, G);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
